mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port E_V1, input, 32 bits: rs operand from the ID/EX register, already forwarded.
REQ-004 SHALL have port E_V2, input, 32 bits: rt operand from the ID/EX register, already forwarded.
REQ-005 SHALL have port MDUOp_E, input, 4 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-006 SHALL have port E_MDU_start, output, 1 bit: combinational; 1 when MDUOp_E is 1-4 and busy is 0.
REQ-007 SHALL have port E_MDU_busy, output, 1 bit: registered; 1 while an operation is in flight.
REQ-008 SHALL have port E_MDU_out, output, 32 bits: combinational; HI when MDUOp_E=5, LO when MDUOp_E=6, else 0.

Function
REQ-009 SHALL hold internal registers HI[31:0], LO[31:0], cnt[3:0], op_latched, and operand latches A[31:0], B[31:0].
REQ-010 SHALL have two states. IDLE: busy=0. RUN: busy=1, cnt>0.
REQ-011 Start: when IDLE and MDUOp_E is 1-4 at edge N, SHALL latch E_V1, E_V2 and the op, and enter RUN with cnt=5 (mult/multu) or cnt=10 (div/divu).
REQ-012 In RUN, SHALL decrement cnt by 1 each edge; at the edge where cnt goes 1->0, SHALL write HI/LO and return to IDLE.
REQ-013 Busy timing: busy SHALL be 1 for exactly 5 cycles (mult/multu) or 10 cycles (div/divu), beginning in cycle N+1.
REQ-014 HI/LO update: the new values SHALL be visible in the first cycle with busy=0.
REQ-015 mult SHALL compute the signed 64-bit product of A and B; multu SHALL compute the unsigned 64-bit product. {HI,LO}=product.
REQ-016 div SHALL use signed division: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu SHALL use unsigned division.
REQ-017 div with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-018 Divide by zero (B=0, div or divu) SHALL run the full 10 busy cycles and leave HI and LO unchanged.
REQ-019 mthi/mtlo SHALL write E_V1 into HI/LO at the edge only when IDLE and not starting; while RUN they SHALL be ignored.
REQ-020 mfhi/mflo SHALL read the current register value combinationally; during RUN the output SHALL reflect the old HI/LO. Stalling the reader is the hazard unit's job via E_MDU_start|E_MDU_busy.
REQ-021 Start while RUN (MDUOp_E 1-4) SHALL be ignored; the in-flight operation and its latched operands SHALL be unaffected.
REQ-022 Operands SHALL be sampled only at the start edge; later changes on E_V1/E_V2 SHALL not affect the result.
REQ-023 Upstream behaviour: a bubble from the ID/EX register (all controls 0) decodes as none and SHALL have no effect.

Reset
REQ-024 Reset asserted SHALL immediately force HI=0, LO=0, cnt=0, busy=0, state IDLE, A=B=0, with no clock edge required.
REQ-025 Reset mid-operation SHALL abort the operation with no HI/LO write; after release, the next start SHALL behave as from power-up.
REQ-026 Outputs during reset: E_MDU_out and E_MDU_start SHALL depend only on MDUOp_E and the cleared registers.

Verification
REQ-027 Signed mult: mult with E_V1=0xFFFFFFFE (-2), E_V2=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 Unsigned mult: multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
REQ-029 Signed div: div -7 / 2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). The same operation with divu 7/0 -> HI/LO unchanged.
REQ-030 Move and ignored ops: mthi 0x12345678, then mfhi -> E_MDU_out=0x12345678. mtlo issued during RUN -> LO unchanged.
REQ-031 Reset mid-operation: start div, assert reset asynchronously in busy cycle 4 -> busy=0 and HI=LO=0 before the next edge; no later write.
REQ-032 Start while busy: mult 2x3, then div 9/3 issued at busy cycle 2 -> div ignored, HI=0, LO=6, busy lasts exactly 5 cycles.

Source files
------------

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- multi-cycle multiply/divide unit for the EX stage.
//
// Owns the architectural HI/LO registers. A mult/multu/div/divu issued while
// idle latches its operands and keeps E_MDU_busy high for a fixed number of
// cycles (5 for multiplies, 10 for divides). HI/LO are written on the final
// busy edge, so the new values are visible in the first idle cycle.
// mthi/mtlo write HI/LO directly when idle; mfhi/mflo read them combinationally.
//
// Ports
//   clk          : single clock, rising-edge active
//   reset        : asynchronous, active-high; clears all state immediately
//   E_V1         : rs operand (already forwarded)
//   E_V2         : rt operand (already forwarded)
//   MDUOp_E      : 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                  5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
//   E_MDU_start  : combinational, high when a mult/div is accepted this cycle
//   E_MDU_busy   : registered, high while an operation is in flight
//   E_MDU_out    : combinational, HI for mfhi, LO for mflo, else 0
//   o_dbg_state  : FSM state for observation (0 IDLE, 1 RUN)
//
// Handshake: E_MDU_start is a one-cycle accept pulse, not a valid/ready pair.
// An op 1-4 presented while busy is dropped, not held; the hazard unit must
// stall dependent instructions on (E_MDU_start | E_MDU_busy).
// -----------------------------------------------------------------------------
module mdu_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    input  logic [3:0]  MDUOp_E,
    output logic        E_MDU_start,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out,
    output logic        o_dbg_state
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_md_op;
    logic        w_is_mul_op;
    logic        w_start;
    logic        w_finish;

    // ------------------------------------------------------------------
    // Decode of the incoming op
    // ------------------------------------------------------------------
    assign w_is_md_op  = (MDUOp_E == OP_MULT) || (MDUOp_E == OP_MULTU) ||
                         (MDUOp_E == OP_DIV)  || (MDUOp_E == OP_DIVU);
    assign w_is_mul_op = (MDUOp_E == OP_MULT) || (MDUOp_E == OP_MULTU);

    // ------------------------------------------------------------------
    // FSM: state and countdown register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM: next state. w_finish marks the edge where cnt goes 1 -> 0,
    // which is the edge that commits HI/LO.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_md_op) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = w_is_mul_op ? MUL_CYCLES : DIV_CYCLES;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand / op latches: sampled only on the accepting edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= 4'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
        end else if (w_start) begin
            r_op <= MDUOp_E;
            r_a  <= E_V1;
            r_b  <= E_V2;
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    logic        w_op_signed;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_div;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_by_zero;

    assign w_op_signed = (r_op == OP_MULT) || (r_op == OP_DIV);

    // Low 64 bits of the product of sign-extended operands equal the
    // two's-complement signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed division via magnitudes: quotient sign = sign(A) xor sign(B),
    // remainder sign = sign(A). For 0x80000000 / -1 the magnitude of A is
    // 0x80000000 and the quotient stays 0x80000000 with remainder 0.
    assign w_a_mag       = (w_op_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_b_mag       = (w_op_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_div_by_zero = (r_b == 32'd0);
    // Keep the divider away from a zero divisor; the result is discarded then.
    assign w_b_div       = w_div_by_zero ? 32'd1 : w_b_mag;
    assign w_q_mag       = w_a_mag / w_b_div;
    assign w_r_mag       = w_a_mag % w_b_div;
    assign w_quot        = (w_op_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem         = (w_op_signed && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    // ------------------------------------------------------------------
    // HI / LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_finish) begin
            case (r_op)
                OP_MULT: begin
                    r_hi <= w_prod_s[63:32];
                    r_lo <= w_prod_s[31:0];
                end
                OP_MULTU: begin
                    r_hi <= w_prod_u[63:32];
                    r_lo <= w_prod_u[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    if (!w_div_by_zero) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end else if (r_state == ST_IDLE) begin
            // mthi/mtlo are never start ops, so IDLE alone implies "not starting".
            if (MDUOp_E == OP_MTHI) begin
                r_hi <= E_V1;
            end else if (MDUOp_E == OP_MTLO) begin
                r_lo <= E_V1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign E_MDU_start = w_start;
    assign E_MDU_busy  = (r_state == ST_RUN);
    assign o_dbg_state = (r_state == ST_RUN);

    always_comb begin
        E_MDU_out = 32'd0;
        if (MDUOp_E == OP_MFHI) begin
            E_MDU_out = r_hi;
        end else if (MDUOp_E == OP_MFLO) begin
            E_MDU_out = r_lo;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit -- self-checking bench for mdu_unit.
// A behavioural model (HI/LO, remaining busy cycles, pending result computed
// with 64-bit integer arithmetic at issue time) is compared against the DUT
// outputs on every falling edge. Directed sequences add literal expectations,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic [3:0]  MDUOp_E;
  logic        E_MDU_start;
  logic        E_MDU_busy;
  logic [31:0] E_MDU_out;
  logic        o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_unit dut (
    .clk         (clk),
    .reset       (reset),
    .E_V1        (E_V1),
    .E_V2        (E_V2),
    .MDUOp_E     (MDUOp_E),
    .E_MDU_start (E_MDU_start),
    .E_MDU_busy  (E_MDU_busy),
    .E_MDU_out   (E_MDU_out),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [31:0] m_nhi  = 32'd0;
  logic [31:0] m_nlo  = 32'd0;
  bit          m_wr   = 1'b0;
  int          m_left = 0;

  task automatic model_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output bit wr);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = 32'd0;
    lo = 32'd0;
    wr = 1'b1;
    case (op)
      4'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      4'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      4'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
      end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_wr = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_wr) begin
        m_hi = m_nhi;
        m_lo = m_nlo;
      end
    end else begin
      case (MDUOp_E)
        4'd1, 4'd2, 4'd3, 4'd4: begin
          model_calc(MDUOp_E, E_V1, E_V2, m_nhi, m_nlo, m_wr);
          m_left = (MDUOp_E <= 4'd2) ? 5 : 10;
        end
        4'd7: m_hi = E_V1;
        4'd8: m_lo = E_V1;
        default: ;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic        exp_busy;
    logic        exp_start;
    logic [31:0] exp_out;
    exp_busy  = (m_left > 0);
    exp_start = (MDUOp_E >= 4'd1) && (MDUOp_E <= 4'd4) && !exp_busy;
    exp_out   = (MDUOp_E == 4'd5) ? m_hi : ((MDUOp_E == 4'd6) ? m_lo : 32'd0);
    chk("cmp_busy",  {31'd0, E_MDU_busy},  {31'd0, exp_busy});
    chk("cmp_start", {31'd0, E_MDU_start}, {31'd0, exp_start});
    chk("cmp_out",   E_MDU_out, exp_out);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    MDUOp_E = op;
    E_V1    = a;
    E_V2    = b;
  endtask

  // Issue one op, keep reading HI (with scrambled operands) while busy, optionally
  // injecting another op at busy cycle inj_at, then check busy length, HI and LO.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_len, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int inj_at, input logic [3:0] inj_op,
                       input logic [31:0] inj_a, input logic [31:0] inj_b);
    int len;
    bit done;
    len  = 0;
    done = 1'b0;
    drive(op, a, b);
    #2;
    chk({name, "_start"}, {31'd0, E_MDU_start}, 32'd1);
    for (int i = 0; i < 20 && !done; i++) begin
      if (i + 1 == inj_at) drive(inj_op, inj_a, inj_b);
      else drive(4'd5, $urandom, $urandom);
      #2;
      if (E_MDU_busy) len++;
      else begin
        done = 1'b1;
        chk({name, "_hi"}, E_MDU_out, exp_hi);
      end
    end
    chk({name, "_len"}, 32'(len), 32'(exp_len));
    drive(4'd6, $urandom, $urandom);
    #2;
    chk({name, "_lo"}, E_MDU_out, exp_lo);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset   = 1'b1;
    MDUOp_E = 4'd0;
    E_V1    = 32'd0;
    E_V2    = 32'd0;
    repeat (2) @(posedge clk);
    // Outputs during reset depend only on MDUOp_E and cleared registers.
    #1 MDUOp_E = 4'd1;
    #1 chk("rst_start", {31'd0, E_MDU_start}, 32'd1);
    chk("rst_busy", {31'd0, E_MDU_busy}, 32'd0);
    MDUOp_E = 4'd5;
    #1 chk("rst_mfhi", E_MDU_out, 32'd0);
    MDUOp_E = 4'd0;
    @(negedge clk);
    reset = 1'b0;

    drive(4'd6, 32'd0, 32'd0);
    #2 chk("init_lo", E_MDU_out, 32'd0);

    do_op("mult_neg",  4'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, 0, 4'd0, 0, 0);
    do_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, 0, 4'd0, 0, 0);
    do_op("div_neg",   4'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 4'd0, 0, 0);
    // divide by zero with an mtlo slipped in mid-run: both must leave HI/LO alone
    do_op("divu_zero", 4'd4, 32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 3, 4'd8, 32'hDEADBEEF, 0);
    do_op("div_ovf",   4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0, 4'd0, 0, 0);

    drive(4'd7, 32'h12345678, 32'd0);
    drive(4'd5, 32'd0, 32'd0);
    #2 chk("mthi_mfhi", E_MDU_out, 32'h12345678);

    // start-while-busy: div 9/3 at busy cycle 2 must be dropped
    do_op("mult_2x3",  4'd1, 32'd2,        32'd3,        5,  32'h00000000, 32'h00000006, 2, 4'd3, 32'd9, 32'd3);
    repeat (12) drive(4'd6, $urandom, $urandom);
    #2 chk("no_late_div", E_MDU_out, 32'h00000006);

    // reset during busy cycle 4 of a divide
    drive(4'd3, 32'd100, 32'd7);
    repeat (3) drive(4'd0, 32'd0, 32'd0);
    drive(4'd5, 32'd0, 32'd0);
    #1 chk("pre_rst_busy", {31'd0, E_MDU_busy}, 32'd1);
    #1 reset = 1'b1;
    #1 chk("async_rst_busy", {31'd0, E_MDU_busy}, 32'd0);
    chk("async_rst_hi", E_MDU_out, 32'd0);
    #2 reset = 1'b0;
    repeat (12) drive(4'd6, 32'd0, 32'd0);
    #2 chk("rst_no_write_lo", E_MDU_out, 32'd0);
    do_op("post_rst_mult", 4'd2, 32'd5, 32'd9, 5, 32'd0, 32'd45, 0, 4'd0, 0, 0);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: b = $urandom;
      endcase
      drive(op, a, b);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    repeat (12) drive(4'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
